fetch_stage: RTL and testbench

Instruction fetch stage sitting directly upstream of the pipelined datapath: it owns the fetch PC, issues word reads to instruction memory over a valid/ready request channel, buffers in-order responses in a small queue and presents `InstrF`/`PCF` to the Fetch→Decode register. It absorbs variable memory latency and decode stalls, and handles branch/PC-write redirects from writeback by flushing the queue and discarding stale in-flight responses.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_stage.sv | 123 ++++++++++++
 tb/tb_fetch_stage.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    localparam int          FETCH_DEPTH_DEFAULT = 4;
    localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] next_word(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs; clear beats push/pop.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CAP     = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CAP);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: state registers use <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // NOTE: storage is reset as well so the head (InstrF/PCF) reads zero out of reset.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !do_pop)      count <= count + CNT_ONE;
            else if (do_pop && !do_push) count <= count - CNT_ONE;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the fetch PC, issues credit-limited imem reads, queues in-order
// responses for decode and drops stale responses after a writeback redirect.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = FETCH_DEPTH_DEFAULT,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic        InstrValidF,
    input  logic        StallD,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW
);

    localparam int          CW         = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_ONE  = 1;
    localparam logic [CW-1:0] CREDITS  = DEPTH[CW-1:0];
    localparam logic [31:0] PC_ALIGNED = RESET_PC & ~32'h3;

    fetch_state_t  state, state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fill;
    logic [CW-1:0] in_flight_after;
    logic          credit_ok;
    logic          resp_seen;
    logic          accept;
    logic          keep;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    fetch_entry_t  head;
    fetch_entry_t  entry;

    assign redirect_pc     = ResultW & ~32'h3;
    assign credit_ok       = (outstanding + fill) < CREDITS;
    assign resp_seen       = imem_resp_valid && (outstanding != '0);
    assign in_flight_after = outstanding - (resp_seen ? CNT_ONE : '0);
    assign accept          = imem_req_valid && imem_req_ready;
    assign keep            = (state == RUN) && !PCSrcW && resp_seen;
    assign pop             = InstrValidF && !StallD && !PCSrcW;
    assign entry           = '{pc: resp_pc, instr: imem_resp_data};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_queue (
        .clk   (clk),
        .rst_n (reset),
        .clear (PCSrcW),
        .push  (keep),
        .wdata (entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fill)
    );

    assign InstrF        = head.instr;
    assign PCF           = head.pc;
    assign InstrValidF   = !fifo_empty;
    assign imem_req_addr = fetch_pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= RUN;
        else        state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        if (PCSrcW)
            state_next = (in_flight_after != '0) ? DRAIN : RUN;
        else if (state == DRAIN && resp_seen && drop_cnt == CNT_ONE)
            state_next = RUN;
    end

    always_comb begin
        imem_req_valid = 1'b0;
        if (reset && state == RUN && !PCSrcW && credit_ok)
            imem_req_valid = 1'b1;
    end

    // Redirect wins over issue, enqueue and drop accounting in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= PC_ALIGNED;
            resp_pc     <= PC_ALIGNED;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (PCSrcW) begin
            fetch_pc    <= redirect_pc;
            resp_pc     <= redirect_pc;
            outstanding <= in_flight_after;
            drop_cnt    <= in_flight_after;
        end else begin
            if (accept) fetch_pc <= next_word(fetch_pc);
            if (keep)   resp_pc  <= next_word(resp_pc);
            case ({accept, resp_seen})
                2'b10:   outstanding <= outstanding + CNT_ONE;
                2'b01:   outstanding <= outstanding - CNT_ONE;
                default: ;
            endcase
            if (state == DRAIN && resp_seen) drop_cnt <= drop_cnt - CNT_ONE;
        end
    end

    resp_into_full_queue: assert property (@(posedge clk) disable iff (!reset) !(keep && fifo_full));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table plus multi-cycle redirect/reset sequences.
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam logic [31:0] KEY = 32'h1300_0000;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic        InstrValidF;
    logic        StallD;
    logic        PCSrcW;
    logic [31:0] ResultW;

    int n_cmp  = 0;
    int n_fail = 0;

    fetch_stage #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .InstrF          (InstrF),
        .PCF             (PCF),
        .InstrValidF     (InstrValidF),
        .StallD          (StallD),
        .PCSrcW          (PCSrcW),
        .ResultW         (ResultW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: in-order, fixed latency, data = addr ^ KEY, reset with the DUT.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    mem_req_t pend[$];
    int cyc       = 0;
    int mem_lat   = 1;
    int acc_total = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend.delete();
            acc_total = 0;
            imem_resp_valid <= 1'b0;
            imem_resp_data  <= '0;
        end else begin
            cyc = cyc + 1;
            if (imem_req_valid && imem_req_ready) begin
                pend.push_back('{imem_req_addr, cyc + mem_lat - 1});
                acc_total++;
            end
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_resp_valid <= 1'b1;
                imem_resp_data  <= pend[0].addr ^ KEY;
                void'(pend.pop_front());
            end else begin
                imem_resp_valid <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        StallD = 1'b0;
        PCSrcW = 1'b0;
        ResultW = '0;
        imem_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    logic [31:0] exp_pc;
    int          n_taken;

    task automatic run_stream(input int cycles, input bit ready_toggle, input int stall_every);
        for (int i = 0; i < cycles; i++) begin
            imem_req_ready = ready_toggle ? (i % 2 == 0) : 1'b1;
            StallD = (stall_every != 0) && (i % stall_every == stall_every - 1);
            PCSrcW = 1'b0;
            #1;
            if (InstrValidF && !StallD) begin
                check("stream_pc", PCF, exp_pc);
                check("stream_instr", InstrF, exp_pc ^ KEY);
                exp_pc = exp_pc + 32'd4;
                n_taken++;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_first(input string name, input logic [31:0] want_pc);
        bit found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            StallD = 1'b0;
            PCSrcW = 1'b0;
            imem_req_ready = 1'b1;
            #1;
            if (InstrValidF) found = 1'b1;
            else @(negedge clk);
        end
        check({name, "_seen"}, 32'(found), 32'd1);
        check({name, "_pc"}, PCF, want_pc);
        check({name, "_instr"}, InstrF, want_pc ^ KEY);
        @(negedge clk);
    endtask

    typedef struct {
        logic        stall;
        logic        pcsrc;
        logic [31:0] resultw;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_req;
        logic [31:0] exp_addr;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    initial begin
        // Cycle 0 = first cycle after reset release; 1-cycle memory, always ready.
        vecs[0]  = '{0, 0, 32'h0,   0, 32'h00,  1, 32'h00};
        vecs[1]  = '{0, 0, 32'h0,   0, 32'h00,  1, 32'h04};
        vecs[2]  = '{0, 0, 32'h0,   1, 32'h00,  1, 32'h08};
        vecs[3]  = '{0, 0, 32'h0,   1, 32'h04,  1, 32'h0C};
        vecs[4]  = '{1, 0, 32'h0,   1, 32'h08,  1, 32'h10};
        vecs[5]  = '{1, 0, 32'h0,   1, 32'h08,  1, 32'h14};
        vecs[6]  = '{1, 0, 32'h0,   1, 32'h08,  0, 32'h00};
        vecs[7]  = '{1, 0, 32'h0,   1, 32'h08,  0, 32'h00};
        vecs[8]  = '{0, 0, 32'h0,   1, 32'h08,  0, 32'h00};
        vecs[9]  = '{0, 0, 32'h0,   1, 32'h0C,  1, 32'h18};
        vecs[10] = '{0, 0, 32'h0,   1, 32'h10,  1, 32'h1C};
        vecs[11] = '{0, 0, 32'h0,   1, 32'h14,  1, 32'h20};
        vecs[12] = '{0, 1, 32'h103, 1, 32'h18,  0, 32'h00};
        vecs[13] = '{0, 0, 32'h0,   0, 32'h00,  1, 32'h100};
        vecs[14] = '{0, 0, 32'h0,   0, 32'h00,  1, 32'h104};
        vecs[15] = '{0, 0, 32'h0,   1, 32'h100, 1, 32'h108};
        vecs[16] = '{0, 0, 32'h0,   1, 32'h104, 1, 32'h10C};

        reset = 1'b0;
        StallD = 1'b0;
        PCSrcW = 1'b0;
        ResultW = '0;
        imem_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_instr", InstrF, 32'h0);
        check("rst_pc", PCF, 32'h0);
        check("rst_valid", InstrValidF, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Table: streaming, stall-induced back-pressure, redirect coincident with a response.
        for (int i = 0; i < NV; i++) begin
            StallD  = vecs[i].stall;
            PCSrcW  = vecs[i].pcsrc;
            ResultW = vecs[i].resultw;
            #1;
            check($sformatf("vec%0d_valid", i), InstrValidF, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_pc", i), PCF, vecs[i].exp_pc);
                check($sformatf("vec%0d_instr", i), InstrF, vecs[i].exp_pc ^ KEY);
            end
            check($sformatf("vec%0d_req_valid", i), imem_req_valid, vecs[i].exp_req);
            if (vecs[i].exp_req)
                check($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].exp_addr);
            @(negedge clk);
        end
        PCSrcW = 1'b0;

        // Long stall: credit caps requests at DEPTH, nothing lost afterwards.
        do_reset();
        mem_lat = 1;
        StallD = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("stall_credit", 32'(acc_total <= 4), 32'd1);
            @(negedge clk);
        end
        #1;
        check("stall_req_valid", imem_req_valid, 1'b0);
        check("stall_valid", InstrValidF, 1'b1);
        check("stall_pc", PCF, 32'h0);
        check("stall_instr", InstrF, KEY);
        check("stall_accepts", acc_total, 32'd4);
        exp_pc = 32'h0;
        n_taken = 0;
        run_stream(20, 1'b0, 0);
        check("stall_release_taken", n_taken, 32'd20);

        // Toggling ready, latency 3, periodic decode stalls.
        do_reset();
        mem_lat = 3;
        exp_pc = 32'h0;
        n_taken = 0;
        run_stream(60, 1'b1, 5);
        check("toggle_progress", 32'(n_taken >= 15), 32'd1);

        // Redirect with three requests in flight: DRAIN drops all three.
        do_reset();
        mem_lat = 5;
        repeat (3) @(negedge clk);
        imem_req_ready = 1'b0;
        PCSrcW = 1'b1;
        ResultW = 32'h100;
        #1;
        check("drain3_req_blocked", imem_req_valid, 1'b0);
        @(negedge clk);
        PCSrcW = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        check("drain3_state", 32'(dut.state == DRAIN), 32'd1);
        check("drain3_dropcnt", 32'(dut.drop_cnt), 32'd3);
        begin
            int n_drain = 0;
            for (int i = 0; i < 20 && dut.state == DRAIN; i++) begin
                #1;
                check("drain3_no_req", imem_req_valid, 1'b0);
                check("drain3_no_valid", InstrValidF, 1'b0);
                n_drain++;
                @(negedge clk);
            end
            check("drain3_cycles", n_drain, 32'd4);
        end
        wait_first("drain3_first", 32'h100);

        // Redirect coincident with a response while decode stalls.
        do_reset();
        mem_lat = 2;
        StallD = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("coinc_pre_valid", InstrValidF, 1'b1);
        PCSrcW = 1'b1;
        ResultW = 32'h200;
        @(negedge clk);
        PCSrcW = 1'b0;
        #1;
        check("coinc_flushed", InstrValidF, 1'b0);
        check("coinc_state", 32'(dut.state == DRAIN), 32'd1);
        check("coinc_dropcnt", 32'(dut.drop_cnt), 32'd1);
        check("coinc_outstanding", 32'(dut.outstanding), 32'd1);
        @(negedge clk);
        wait_first("coinc_first", 32'h200);

        // PC wrap at the top of the address space; ResultW low bits ignored.
        do_reset();
        mem_lat = 1;
        PCSrcW = 1'b1;
        ResultW = 32'hFFFF_FFFF;
        #1;
        check("wrap_redirect_block", imem_req_valid, 1'b0);
        @(negedge clk);
        PCSrcW = 1'b0;
        #1;
        check("wrap_req0_valid", imem_req_valid, 1'b1);
        check("wrap_req0_addr", imem_req_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        #1;
        check("wrap_req1_addr", imem_req_addr, 32'h0000_0000);
        @(negedge clk);
        exp_pc = 32'hFFFF_FFFC;
        n_taken = 0;
        run_stream(8, 1'b0, 0);
        check("wrap_taken", 32'(n_taken >= 5), 32'd1);

        // Reset in the middle of DRAIN.
        do_reset();
        mem_lat = 5;
        repeat (3) @(negedge clk);
        PCSrcW = 1'b1;
        ResultW = 32'h300;
        @(negedge clk);
        PCSrcW = 1'b0;
        #1;
        check("mrst_in_drain", 32'(dut.state == DRAIN), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        mem_lat = 1;
        #1;
        check("mrst_req_valid", imem_req_valid, 1'b0);
        check("mrst_instr", InstrF, 32'h0);
        check("mrst_pc", PCF, 32'h0);
        check("mrst_valid", InstrValidF, 1'b0);
        check("mrst_dropcnt", 32'(dut.drop_cnt), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mrst_state", 32'(dut.state == RUN), 32'd1);
        check("mrst_first_req", imem_req_valid, 1'b1);
        check("mrst_first_addr", imem_req_addr, 32'h0);
        @(negedge clk);
        exp_pc = 32'h0;
        n_taken = 0;
        run_stream(8, 1'b0, 0);
        check("mrst_taken", 32'(n_taken >= 5), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
